// File: rtl/cam_ternary.sv
// Ternary CAM: per-entry data/mask/valid storage, 1-cycle registered search,
// and a small IDLE/WRITE/FLUSH controller for single-entry updates and bulk flush.
module cam_ternary #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic                  delete_enable,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] cmp_din,
  input  logic [DATA_WIDTH-1:0] write_mask,
  input  logic                  search_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  match_valid,
  output logic                  match,
  output logic [ADDR_WIDTH-1:0] match_addr,
  output logic                  multi_match,
  output logic [ADDR_WIDTH:0]   match_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH} state_t;

  state_t state_q, state_d;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mask_q;
  logic [DEPTH-1:0]                 valid_q;

  logic [ADDR_WIDTH-1:0] op_addr_q;
  logic [DATA_WIDTH-1:0] op_data_q;
  logic [DATA_WIDTH-1:0] op_mask_q;
  logic                  op_write_q;
  logic [ADDR_WIDTH-1:0] flush_cnt_q;

  logic                  accept_op_c;
  logic [DEPTH-1:0]      hit_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic [CW-1:0]         count_c;

  // Next-state logic; flush wins over write, write over delete
  always_comb begin
    state_d     = state_q;
    accept_op_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
        end else if (write_enable || delete_enable) begin
          state_d     = WRITE;
          accept_op_c = 1'b1;
        end
      end
      WRITE: state_d = IDLE;
      FLUSH: begin
        if (flush_cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      op_addr_q   <= '0;
      op_data_q   <= '0;
      op_mask_q   <= '0;
      op_write_q  <= 1'b0;
      flush_cnt_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      if (accept_op_c) begin
        op_addr_q  <= write_addr;
        op_data_q  <= cmp_din;
        op_mask_q  <= write_mask;
        op_write_q <= write_enable;
      end
      if (state_q == WRITE) valid_q[op_addr_q] <= op_write_q;
      // Counter wraps back to zero on the last flush cycle
      if (state_q == FLUSH) begin
        valid_q[flush_cnt_q] <= 1'b0;
        flush_cnt_q          <= flush_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Payload storage needs no reset: invalid entries never match
  always_ff @(posedge clk) begin
    if (state_q == WRITE && op_write_q) begin
      data_q[op_addr_q] <= op_data_q;
      mask_q[op_addr_q] <= op_mask_q;
    end
  end

  // Match vector, lowest-index encoder and population count
  always_comb begin
    hit_c   = '0;
    addr_c  = '0;
    count_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit_c[i] = valid_q[i] && (((din ^ data_q[i]) & mask_q[i]) == '0);
      count_c  = count_c + CW'(hit_c[i]);
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (hit_c[i]) addr_c = ADDR_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_valid <= 1'b0;
      match       <= 1'b0;
      match_addr  <= '0;
      multi_match <= 1'b0;
      match_count <= '0;
    end else begin
      match_valid <= search_valid;
      if (search_valid) begin
        match       <= |hit_c;
        match_addr  <= addr_c;
        multi_match <= (count_c >= CW'(2));
        match_count <= count_c;
      end
    end
  end

endmodule

// File: tb/tb_cam_ternary.sv
// Directed self-checking bench for cam_ternary (DATA_WIDTH=4, ADDR_WIDTH=2):
// table of search vectors plus hand sequences for busy, same-edge and reset cases.
module tb_cam_ternary;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_enable, delete_enable, flush;
  logic [1:0] write_addr;
  logic [3:0] cmp_din, write_mask;
  logic       search_valid;
  logic [3:0] din;
  logic       busy, match_valid, match, multi_match;
  logic [1:0] match_addr;
  logic [2:0] match_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cam_ternary #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .delete_enable(delete_enable),
    .flush(flush), .write_addr(write_addr), .cmp_din(cmp_din), .write_mask(write_mask),
    .search_valid(search_valid), .din(din), .busy(busy), .match_valid(match_valid),
    .match(match), .match_addr(match_addr), .multi_match(multi_match),
    .match_count(match_count)
  );

  typedef struct {
    logic [3:0] key;
    logic       m;
    logic [1:0] addr;
    logic [2:0] cnt;
    logic       multi;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input logic m, input logic [1:0] a,
                         input logic [2:0] c, input logic mu);
    chk({name, ".match_valid"}, int'(match_valid), 1);
    chk({name, ".match"}, int'(match), int'(m));
    chk({name, ".match_addr"}, int'(match_addr), int'(a));
    chk({name, ".match_count"}, int'(match_count), int'(c));
    chk({name, ".multi_match"}, int'(multi_match), int'(mu));
  endtask

  // Bounded wait for the controller to go idle
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, ".idle_timeout"}, 1, 0);
  endtask

  task automatic do_op(input logic we, input logic de, input logic fl,
                       input logic [1:0] a, input logic [3:0] d, input logic [3:0] m);
    write_enable = we; delete_enable = de; flush = fl;
    write_addr = a; cmp_din = d; write_mask = m;
    @(negedge clk);
    write_enable = 1'b0; delete_enable = 1'b0; flush = 1'b0;
    wait_idle("op");
  endtask

  task automatic search(input logic [3:0] key);
    search_valid = 1'b1; din = key;
    @(negedge clk);
    search_valid = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      search(vecs[i].key);
      chk_res($sformatf("vec%0d", i), vecs[i].m, vecs[i].addr, vecs[i].cnt, vecs[i].multi);
    end
  endtask

  initial begin
    int bc;
    vecs[0] = '{4'b1011, 1'b1, 2'd2, 3'd1, 1'b0};
    vecs[1] = '{4'b0011, 1'b1, 2'd0, 3'd1, 1'b0};
    vecs[2] = '{4'b0000, 1'b0, 2'd0, 3'd0, 1'b0};
    vecs[3] = '{4'b1111, 1'b1, 2'd3, 3'd1, 1'b0};
    vecs[4] = '{4'b0101, 1'b1, 2'd1, 3'd1, 1'b0};
    vecs[5] = '{4'b0011, 1'b1, 2'd0, 3'd2, 1'b1};
    vecs[6] = '{4'b0001, 1'b1, 2'd1, 3'd1, 1'b0};
    vecs[7] = '{4'b1011, 1'b1, 2'd2, 3'd1, 1'b0};

    rst = 1'b1; write_enable = 1'b0; delete_enable = 1'b0; flush = 1'b0;
    write_addr = '0; cmp_din = '0; write_mask = '0; search_valid = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    chk("reset.busy", int'(busy), 0);
    chk("reset.match_valid", int'(match_valid), 0);
    chk("reset.match_count", int'(match_count), 0);
    rst = 1'b0;
    @(negedge clk);

    // Fully specified entries
    do_op(1, 0, 0, 2'd0, 4'b0011, 4'b1111);
    do_op(1, 0, 0, 2'd1, 4'b0101, 4'b1111);
    do_op(1, 0, 0, 2'd2, 4'b1011, 4'b1111);
    do_op(1, 0, 0, 2'd3, 4'b1111, 4'b1111);
    run_vecs(0, 4);

    // Without search_valid the results hold and match_valid drops
    @(negedge clk);
    chk("hold.match_valid", int'(match_valid), 0);
    chk("hold.match_addr", int'(match_addr), 1);
    chk("hold.match", int'(match), 1);

    // Don't-care bits in entry 1
    do_op(1, 0, 0, 2'd1, 4'b0000, 4'b1100);
    run_vecs(5, 7);

    // Delete entry 0; a write attempted while busy is dropped
    write_addr = 2'd0; delete_enable = 1'b1;
    @(negedge clk);
    delete_enable = 1'b0;
    chk("delete.busy", int'(busy), 1);
    write_enable = 1'b1; write_addr = 2'd2; cmp_din = 4'b0000; write_mask = 4'b0000;
    @(negedge clk);
    write_enable = 1'b0;
    wait_idle("delete");
    search(4'b0011);
    chk_res("after_delete", 1'b1, 2'd1, 3'd1, 1'b0);

    // Search during WRITE sees the old contents, next cycle sees the new
    write_enable = 1'b1; write_addr = 2'd3; cmp_din = 4'b0110; write_mask = 4'b1111;
    @(negedge clk);
    write_enable = 1'b0;
    chk("wr3.busy", int'(busy), 1);
    search_valid = 1'b1; din = 4'b1111;
    @(negedge clk);
    chk_res("same_edge", 1'b1, 2'd3, 3'd1, 1'b0);
    @(negedge clk);
    search_valid = 1'b0;
    chk_res("post_write", 1'b0, 2'd0, 3'd0, 1'b0);

    // Flush: busy for exactly DEPTH cycles
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      @(negedge clk);
    end
    chk("flush.busy_cycles", bc, 4);
    search(4'b0101);
    chk_res("after_flush", 1'b0, 2'd0, 3'd0, 1'b0);

    // Flush beats a simultaneous write
    do_op(1, 0, 1, 2'd0, 4'b0101, 4'b1111);
    search(4'b0101);
    chk_res("flush_vs_write", 1'b0, 2'd0, 3'd0, 1'b0);

    // All-zero masks: every entry matches, count reaches DEPTH
    for (int i = 0; i < 4; i++) do_op(1, 0, 0, 2'(i), 4'b1010, 4'b0000);
    search(4'b0110);
    chk_res("all_match", 1'b1, 2'd0, 3'd4, 1'b1);

    // Reset two cycles into a flush; search in flush cycle 1 makes outputs nonzero
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    search_valid = 1'b1; din = 4'b0000;
    @(negedge clk);
    search_valid = 1'b0;
    chk_res("flush_search", 1'b1, 2'd0, 3'd4, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst.busy", int'(busy), 0);
    chk("rst.match_valid", int'(match_valid), 0);
    chk("rst.match", int'(match), 0);
    chk("rst.match_count", int'(match_count), 0);
    chk("rst.multi_match", int'(multi_match), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      search(4'(k * 5));
      chk_res($sformatf("post_rst%0d", k), 1'b0, 2'd0, 3'd0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
